// File: rtl/apb3_mem_bridge_pkg.sv
// Shared types and constants for the APB3-to-memory bridge.
package apb_bridge_pkg;

    // APB byte address carries this many byte-offset bits below the word index.
    localparam int unsigned BYTE_OFFSET_WIDTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Error causes are bit flags so a transfer can report both at once.
    typedef logic [1:0] err_cause_t;
    localparam err_cause_t ERR_NONE     = 2'b00;
    localparam err_cause_t ERR_MISALIGN = 2'b01;
    localparam err_cause_t ERR_RANGE    = 2'b10;

endpackage

// File: rtl/apb3_mem_bridge_if.sv
// APB3 slave bus plus the single-port memory strobe bus driven by the bridge.
interface apb3_mem_bridge_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned PADDR_WIDTH   = 12
);
    logic                     iPSEL;
    logic                     iPENABLE;
    logic                     iPWRITE;
    logic [PADDR_WIDTH-1:0]   iPADDR;
    logic [DATA_WIDTH-1:0]    iPWDATA;
    logic [DATA_WIDTH-1:0]    oPRDATA;
    logic                     oPREADY;
    logic                     oPSLVERR;
    logic                     oChipSelect;
    logic                     oRead;
    logic                     oWrite;
    logic [ADDRESS_WIDTH-1:0] oAddress;
    logic [DATA_WIDTH-1:0]    oData;
    logic [DATA_WIDTH-1:0]    iData;

    // Bridge view: APB slave and memory-port master.
    modport slave (
        input  iPSEL, iPENABLE, iPWRITE, iPADDR, iPWDATA, iData,
        output oPRDATA, oPREADY, oPSLVERR, oChipSelect, oRead, oWrite, oAddress, oData
    );

    // Environment view: APB master and memory model.
    modport master (
        output iPSEL, iPENABLE, iPWRITE, iPADDR, iPWDATA, iData,
        input  oPRDATA, oPREADY, oPSLVERR, oChipSelect, oRead, oWrite, oAddress, oData
    );
endinterface

// File: rtl/apb3_mem_bridge_addr_check.sv
// Combinational APB address decode: word index, legality and error cause.
module apb_addr_check
    import apb_bridge_pkg::*;
#(
    parameter int unsigned PADDR_WIDTH   = 12,
    parameter int unsigned ADDRESS_WIDTH = 4
) (
    input  logic [PADDR_WIDTH-1:0]   paddr,
    output logic [ADDRESS_WIDTH-1:0] word_index,
    output logic                     addr_ok,
    output err_cause_t               err_cause
);
    localparam int unsigned IDX_LO = BYTE_OFFSET_WIDTH;
    localparam int unsigned IDX_HI = ADDRESS_WIDTH + BYTE_OFFSET_WIDTH;

    // Flag unaligned byte offsets and any address bit above the memory window.
    always_comb begin
        err_cause  = ERR_NONE;
        word_index = paddr[IDX_HI-1:IDX_LO];
        if (paddr[IDX_LO-1:0] != '0) begin
            err_cause = err_cause | ERR_MISALIGN;
        end
        if ((paddr >> IDX_HI) != '0) begin
            err_cause = err_cause | ERR_RANGE;
        end
        addr_ok = (err_cause == ERR_NONE);
    end
endmodule

// File: rtl/apb3_mem_bridge.sv
// APB3 slave that turns each transfer into one memory strobe cycle and
// counts rejected transfers in a saturating counter.
module apb3_mem_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned PADDR_WIDTH   = 12,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     iClk,
    input  logic                     iReset,
    apb3_mem_bridge_if.slave         bus,
    output logic [ERR_CNT_WIDTH-1:0] oErrCount
);
    state_t                   state;
    state_t                   state_next;
    logic                     setup;
    logic [ADDRESS_WIDTH-1:0] word_index;
    logic                     addr_ok;
    err_cause_t               cause;

    logic                     wr_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    err_cause_t               cause_q;
    logic                     err_q;

    apb_addr_check #(
        .PADDR_WIDTH   (PADDR_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_addr_check (
        .paddr      (bus.iPADDR),
        .word_index (word_index),
        .addr_ok    (addr_ok),
        .err_cause  (cause)
    );

    assign setup        = bus.iPSEL & ~bus.iPENABLE;
    assign err_q        = (cause_q != ERR_NONE);
    assign bus.oAddress = addr_q;
    assign bus.oData    = wdata_q;

    // State register.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the setup-phase request; held until the next accepted setup.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cause_q <= ERR_NONE;
        end else if (state == ST_IDLE && setup) begin
            wr_q    <= bus.iPWRITE;
            addr_q  <= word_index;
            wdata_q <= bus.iPWDATA;
            cause_q <= cause;
        end
    end

    // Count errored transfers as they complete, holding at all-ones.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            oErrCount <= '0;
        end else if (state == ST_DONE && err_q && oErrCount != '1) begin
            oErrCount <= oErrCount + 1'b1;
        end
    end

    // Next-state and Moore outputs; a bad address skips the memory strobe.
    always_comb begin
        state_next      = state;
        bus.oChipSelect = 1'b0;
        bus.oRead       = 1'b0;
        bus.oWrite      = 1'b0;
        bus.oPREADY     = 1'b0;
        bus.oPSLVERR    = 1'b0;
        bus.oPRDATA     = '0;
        case (state)
            ST_IDLE: begin
                if (setup) begin
                    state_next = addr_ok ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                bus.oChipSelect = 1'b1;
                bus.oWrite      = wr_q;
                bus.oRead       = ~wr_q;
                state_next      = ST_DONE;
            end
            ST_DONE: begin
                bus.oPREADY  = 1'b1;
                bus.oPSLVERR = err_q;
                if (!wr_q && !err_q) begin
                    bus.oPRDATA = bus.iData;
                end
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end
endmodule
